sym_vn_rank_addr_lut: RTL and testbench

//  Four-port symmetric 2-input VN IB-LUT read path for the layered decoder's VNU.

---
 rtl/sym_vn_rank_addr_lut_if.sv | 60 ++++++
 rtl/sym_vn_rank_addr_lut.sv | 152 +++++++++++++++
 tb/tb_sym_vn_rank_addr_lut.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sym_vn_rank_addr_lut_if.sv
// ---------------------------------------------------------------------------
// SymVnRankAddrLutIf
// Bundles the four read ports, the shared read frame select, the LUT results
// and the page write port of the symmetric VN IB-LUT into one interface.
//
// Port summary (widths from the parameters below):
//   y0_in_A..D, y1_in_A..D  QUAN_SIZE      incoming message pairs, one per read port
//   read_addr_offset        OW             frame select for reads, shared by all ports
//   t_c_A..D                QUAN_SIZE      LUT result per read port
//   transpose_en_outA..D    1              sign of y0 delayed to line up with t_c
//   read_addr_offset_out    OW             read frame select delayed to line up with t_c
//   lut_in_bank0/1          LUT_PORT_SIZE  write data for bank 0 / bank 1
//   page_write_addr         PW             page being written
//   write_addr_offset       OW             frame being written
//   we                      1              write enable
//
// The master modport is the decoder side that drives messages and LUT
// contents; the slave modport is the LUT read path itself.
// ---------------------------------------------------------------------------
interface sym_vn_rank_addr_lut_if #(
   parameter int QUAN_SIZE       = 3,
   parameter int LUT_PORT_SIZE   = 3,
   parameter int ENTRY_ADDR      = 5,
   parameter int MULTI_FRAME_NUM = 2
);
   localparam int OW = $clog2(MULTI_FRAME_NUM);
   localparam int PW = ENTRY_ADDR - OW;

   logic [QUAN_SIZE-1:0]     y0_in_A, y0_in_B, y0_in_C, y0_in_D;
   logic [QUAN_SIZE-1:0]     y1_in_A, y1_in_B, y1_in_C, y1_in_D;
   logic [OW-1:0]            read_addr_offset;
   logic [QUAN_SIZE-1:0]     t_c_A, t_c_B, t_c_C, t_c_D;
   logic                     transpose_en_outA, transpose_en_outB;
   logic                     transpose_en_outC, transpose_en_outD;
   logic [OW-1:0]            read_addr_offset_out;
   logic [LUT_PORT_SIZE-1:0] lut_in_bank0, lut_in_bank1;
   logic [PW-1:0]            page_write_addr;
   logic [OW-1:0]            write_addr_offset;
   logic                     we;

   modport master (
      output y0_in_A, y0_in_B, y0_in_C, y0_in_D,
      output y1_in_A, y1_in_B, y1_in_C, y1_in_D,
      output read_addr_offset,
      output lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
      input  t_c_A, t_c_B, t_c_C, t_c_D,
      input  transpose_en_outA, transpose_en_outB, transpose_en_outC, transpose_en_outD,
      input  read_addr_offset_out
   );

   modport slave (
      input  y0_in_A, y0_in_B, y0_in_C, y0_in_D,
      input  y1_in_A, y1_in_B, y1_in_C, y1_in_D,
      input  read_addr_offset,
      input  lut_in_bank0, lut_in_bank1, page_write_addr, write_addr_offset, we,
      output t_c_A, t_c_B, t_c_C, t_c_D,
      output transpose_en_outA, transpose_en_outB, transpose_en_outC, transpose_en_outD,
      output read_addr_offset_out
   );
endinterface

// File: rtl/sym_vn_rank_addr_lut.sv
// ---------------------------------------------------------------------------
// sym_vn_rank_addr_lut
// Four-port symmetric 2-input VN IB-LUT read path for the layered decoder's
// VNU. Each message pair (y0,y1) is folded by the sign of y0, mapped onto a
// bank/page address, and looked up in a two-bank, multi-frame LUT RAM. The
// result t_c and a transpose flag (the sign of y0) come out two cycles after
// the inputs are presented. The RAM is filled page-by-page, both banks at
// once, through a single write port on the same clock.
//
// Ports:
//   read_clk  single clock for reads and writes
//   rstn      synchronous active-low reset (pipeline only; RAM is retained)
//   bus       sym_vn_rank_addr_lut_if.slave -- read ports A..D, shared read
//             frame select, LUT results, and the page write port
//
// Build option:
//   SYM_VN_Y0_FOLD_EN  when defined, the low bits of y0 are also inverted by
//                      the sign, giving full symmetric folding of both
//                      messages. Default build folds only y1.
// ---------------------------------------------------------------------------
module sym_vn_rank_addr_lut #(
   parameter int QUAN_SIZE       = 3,
   parameter int LUT_PORT_SIZE   = 3,
   parameter int ENTRY_ADDR      = 5,
   parameter int MULTI_FRAME_NUM = 2
) (
   input logic                   read_clk,
   input logic                   rstn,
   sym_vn_rank_addr_lut_if.slave bus
);

   localparam int OW    = $clog2(MULTI_FRAME_NUM);
   localparam int PW    = ENTRY_ADDR - OW;
   localparam int DEPTH = MULTI_FRAME_NUM * (2 ** PW);
   localparam int NPORT = 4;

   logic [QUAN_SIZE-1:0]     y0_in   [NPORT];
   logic [QUAN_SIZE-1:0]     y1_in   [NPORT];

   logic [LUT_PORT_SIZE-2:0] y0f_d   [NPORT];
   logic [QUAN_SIZE-1:0]     y1f_d   [NPORT];
   logic                     s_d     [NPORT];

   logic [LUT_PORT_SIZE-2:0] y0f_p0  [NPORT];
   logic [QUAN_SIZE-1:0]     y1f_p0  [NPORT];
   logic                     s_p0    [NPORT];
   logic [OW-1:0]            offset_p0;

   logic [ENTRY_ADDR-1:0]    entry_a [NPORT];
   logic [OW+PW-1:0]         rd_idx  [NPORT];
   logic [LUT_PORT_SIZE-1:0] rd_data [NPORT];

   logic [LUT_PORT_SIZE-1:0] data_p1 [NPORT];
   logic                     s_p1    [NPORT];
   logic [OW-1:0]            offset_p1;

   logic [LUT_PORT_SIZE-1:0] bank0   [DEPTH];
   logic [LUT_PORT_SIZE-1:0] bank1   [DEPTH];

   assign y0_in[0] = bus.y0_in_A;
   assign y0_in[1] = bus.y0_in_B;
   assign y0_in[2] = bus.y0_in_C;
   assign y0_in[3] = bus.y0_in_D;
   assign y1_in[0] = bus.y1_in_A;
   assign y1_in[1] = bus.y1_in_B;
   assign y1_in[2] = bus.y1_in_C;
   assign y1_in[3] = bus.y1_in_D;

   // Sign folding: a negative y0 mirrors the pair into the stored half of
   // the symmetric table, so only half the entries need to live in RAM.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         s_d[p]   = y0_in[p][QUAN_SIZE-1];
         y1f_d[p] = s_d[p] ? ~y1_in[p] : y1_in[p];
`ifdef SYM_VN_Y0_FOLD_EN
         y0f_d[p] = s_d[p] ? ~y0_in[p][LUT_PORT_SIZE-2:0] : y0_in[p][LUT_PORT_SIZE-2:0];
`else
         y0f_d[p] = y0_in[p][LUT_PORT_SIZE-2:0];
`endif
      end
   end

   // Stage 0: register the folded messages, sign and frame select.
   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         for (int p = 0; p < NPORT; p++) begin
            y0f_p0[p] <= '0;
            y1f_p0[p] <= '0;
            s_p0[p]   <= 1'b0;
         end
         offset_p0 <= '0;
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            y0f_p0[p] <= y0f_d[p];
            y1f_p0[p] <= y1f_d[p];
            s_p0[p]   <= s_d[p];
         end
         offset_p0 <= bus.read_addr_offset;
      end
   end

   // Entry address LSB picks the bank; the remaining bits are the page
   // within the selected frame. Each port muxes its own bank output, so the
   // four ports never compete for a read.
   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         entry_a[p] = {y0f_p0[p], y1f_p0[p]};
         rd_idx[p]  = {offset_p0, entry_a[p][ENTRY_ADDR-1:1]};
         rd_data[p] = entry_a[p][0] ? bank1[rd_idx[p]] : bank0[rd_idx[p]];
      end
   end

   // Stage 1: capture the looked-up word. A write to the same word on the
   // same edge lands after this read, so the old contents are captured.
   always_ff @(posedge read_clk) begin
      if (!rstn) begin
         for (int p = 0; p < NPORT; p++) begin
            data_p1[p] <= '0;
            s_p1[p]    <= 1'b0;
         end
         offset_p1 <= '0;
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            data_p1[p] <= rd_data[p];
            s_p1[p]    <= s_p0[p];
         end
         offset_p1 <= offset_p0;
      end
   end

   // Page write: both banks share one address. The RAM has no reset so its
   // contents survive a pipeline flush; writes are only blocked during reset.
   always_ff @(posedge read_clk) begin
      if (rstn && bus.we) begin
         bank0[{bus.write_addr_offset, bus.page_write_addr}] <= bus.lut_in_bank0;
         bank1[{bus.write_addr_offset, bus.page_write_addr}] <= bus.lut_in_bank1;
      end
   end

   assign bus.t_c_A = data_p1[0][QUAN_SIZE-1:0];
   assign bus.t_c_B = data_p1[1][QUAN_SIZE-1:0];
   assign bus.t_c_C = data_p1[2][QUAN_SIZE-1:0];
   assign bus.t_c_D = data_p1[3][QUAN_SIZE-1:0];

   assign bus.transpose_en_outA = s_p1[0];
   assign bus.transpose_en_outB = s_p1[1];
   assign bus.transpose_en_outC = s_p1[2];
   assign bus.transpose_en_outD = s_p1[3];

   assign bus.read_addr_offset_out = offset_p1;

endmodule

// File: tb/tb_sym_vn_rank_addr_lut.sv
// ---------------------------------------------------------------------------
// tb_sym_vn_rank_addr_lut
// Directed bench for sym_vn_rank_addr_lut: reset state, page writes and
// lookups per frame, sign folding (both builds via SYM_VN_Y0_FOLD_EN),
// four ports streaming at full rate, read-during-write and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_sym_vn_rank_addr_lut;

   logic clk;
   logic rstn;
   int   errors;
   int   checks;

   // Shadow copy of the LUT RAM, updated by every write the bench issues.
   logic [2:0] mem0 [32];
   logic [2:0] mem1 [32];

   logic [2:0] expTc  [16][4];
   logic       expTe  [16][4];
   logic       expOff [16];

   sym_vn_rank_addr_lut_if bus ();

   sym_vn_rank_addr_lut dut (
      .read_clk (clk),
      .rstn     (rstn),
      .bus      (bus)
   );

   // 100 MHz-style free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one read port's message pair.
   task automatic applyStimulus(input int p, input logic [2:0] y0, input logic [2:0] y1);
      case (p)
         0: begin bus.y0_in_A = y0; bus.y1_in_A = y1; end
         1: begin bus.y0_in_B = y0; bus.y1_in_B = y1; end
         2: begin bus.y0_in_C = y0; bus.y1_in_C = y1; end
         default: begin bus.y0_in_D = y0; bus.y1_in_D = y1; end
      endcase
   endtask

   task automatic clearPorts();
      for (int p = 0; p < 4; p++) applyStimulus(p, 3'b000, 3'b000);
   endtask

   // One page write (both banks), mirrored into the shadow RAM.
   task automatic doWrite(input logic off, input logic [3:0] page, input logic [2:0] b0, input logic [2:0] b1);
      bus.write_addr_offset = off;
      bus.page_write_addr   = page;
      bus.lut_in_bank0      = b0;
      bus.lut_in_bank1      = b1;
      bus.we                = 1'b1;
      tick();
      bus.we = 1'b0;
      mem0[{off, page}] = b0;
      mem1[{off, page}] = b1;
   endtask

   function automatic logic [2:0] getTc(input int p);
      case (p)
         0: return bus.t_c_A;
         1: return bus.t_c_B;
         2: return bus.t_c_C;
         default: return bus.t_c_D;
      endcase
   endfunction

   function automatic logic getTe(input int p);
      case (p)
         0: return bus.transpose_en_outA;
         1: return bus.transpose_en_outB;
         2: return bus.transpose_en_outC;
         default: return bus.transpose_en_outD;
      endcase
   endfunction

   // Reference lookup built from the fold/address rules and the shadow RAM.
   function automatic logic [2:0] modelTc(input logic [2:0] y0, input logic [2:0] y1, input logic off);
      logic       s;
      logic [2:0] y1f;
      logic [1:0] y0f;
      logic [4:0] a;
      logic [4:0] idx;
      s   = y0[2];
      y1f = s ? ~y1 : y1;
`ifdef SYM_VN_Y0_FOLD_EN
      y0f = s ? ~y0[1:0] : y0[1:0];
`else
      y0f = y0[1:0];
`endif
      a   = {y0f, y1f};
      idx = {off, a[4:1]};
      return a[0] ? mem1[idx] : mem0[idx];
   endfunction

   initial begin
      logic [2:0] y0v;
      logic [2:0] y1v;
      logic [2:0] expNeg;
      errors = 0;
      checks = 0;
      rstn   = 1'b0;
      bus.read_addr_offset  = 1'b0;
      bus.write_addr_offset = 1'b0;
      bus.page_write_addr   = 4'd0;
      bus.lut_in_bank0      = 3'd0;
      bus.lut_in_bank1      = 3'd0;
      bus.we                = 1'b0;
      clearPorts();
`ifdef SYM_VN_Y0_FOLD_EN
      expNeg = 3'b010;
`else
      expNeg = 3'b111;
`endif

      // Reset state: every output is zero.
      tick();
      tick();
      for (int p = 0; p < 4; p++) begin
         checkOutput($sformatf("reset_tc%0d", p), {5'd0, getTc(p)}, 8'd0);
         checkOutput($sformatf("reset_te%0d", p), {7'd0, getTe(p)}, 8'd0);
      end
      checkOutput("reset_off", {7'd0, bus.read_addr_offset_out}, 8'd0);
      rstn = 1'b1;
      tick();

      // Fill both frames of both banks with a known pattern.
      for (int i = 0; i < 32; i++) begin
         doWrite(i[4], i[3:0], 3'((i * 3 + 1) & 7), 3'((i * 5 + 2) & 7));
      end

      // Test 1: page 5, frame 0 written, port A lands on bank 0.
      doWrite(1'b0, 4'd5, 3'b011, 3'b110);
      applyStimulus(0, 3'b001, 3'b010);
      bus.read_addr_offset = 1'b0;
      tick();
      tick();
      checkOutput("t1_tcA", {5'd0, bus.t_c_A}, 8'h03);
      checkOutput("t1_teA", {7'd0, bus.transpose_en_outA}, 8'h00);

      // Test 2: same page in frame 1, then frame 0 again back to back.
      doWrite(1'b1, 4'd5, 3'b100, 3'b001);
      bus.read_addr_offset = 1'b1;
      tick();
      bus.read_addr_offset = 1'b0;
      tick();
      checkOutput("t2_tcA_off1", {5'd0, bus.t_c_A}, 8'h04);
      checkOutput("t2_offout1", {7'd0, bus.read_addr_offset_out}, 8'h01);
      tick();
      checkOutput("t2_tcA_off0", {5'd0, bus.t_c_A}, 8'h03);
      checkOutput("t2_offout0", {7'd0, bus.read_addr_offset_out}, 8'h00);

      // Test 3: negative y0; page 6 bank 1 (default) vs page 10 bank 1 (full fold).
      doWrite(1'b0, 4'd6, 3'b000, 3'b111);
      doWrite(1'b0, 4'd10, 3'b001, 3'b010);
      applyStimulus(0, 3'b101, 3'b010);
      tick();
      tick();
      checkOutput("t3_tcA", {5'd0, bus.t_c_A}, {5'd0, expNeg});
      checkOutput("t3_teA", {7'd0, bus.transpose_en_outA}, 8'h01);

      // Test 4: four ports, new vectors every cycle for 16 cycles.
      for (int j = 0; j <= 16; j++) begin
         if (j < 16) begin
            for (int p = 0; p < 4; p++) begin
               y0v = 3'((j * 3 + p * 5 + 1) & 7);
               y1v = 3'((j * 5 + p * 2 + 3) & 7);
               applyStimulus(p, y0v, y1v);
               expTc[j][p] = modelTc(y0v, y1v, j[0]);
               expTe[j][p] = y0v[2];
            end
            bus.read_addr_offset = j[0];
            expOff[j] = j[0];
         end
         tick();
         if (j >= 1) begin
            for (int p = 0; p < 4; p++) begin
               checkOutput($sformatf("t4_tc_c%0d_p%0d", j - 1, p), {5'd0, getTc(p)}, {5'd0, expTc[j-1][p]});
               checkOutput($sformatf("t4_te_c%0d_p%0d", j - 1, p), {7'd0, getTe(p)}, {7'd0, expTe[j-1][p]});
            end
            checkOutput($sformatf("t4_off_c%0d", j - 1), {7'd0, bus.read_addr_offset_out}, {7'd0, expOff[j-1]});
         end
      end

      // Test 5: write lands on the edge that captures the read of the same word.
      clearPorts();
      applyStimulus(0, 3'b001, 3'b010);
      bus.read_addr_offset = 1'b0;
      tick();
      doWrite(1'b0, 4'd5, 3'b101, 3'b110);
      checkOutput("t5_old", {5'd0, bus.t_c_A}, 8'h03);
      tick();
      checkOutput("t5_new", {5'd0, bus.t_c_A}, 8'h05);

      // Test 6: one-cycle reset mid-stream with a write attempt during it.
      applyStimulus(1, 3'b101, 3'b010);
      tick();
      rstn                  = 1'b0;
      bus.write_addr_offset = 1'b0;
      bus.page_write_addr   = 4'd5;
      bus.lut_in_bank0      = 3'b000;
      bus.lut_in_bank1      = 3'b000;
      bus.we                = 1'b1;
      tick();
      for (int p = 0; p < 4; p++) begin
         checkOutput($sformatf("t6_rst_tc%0d", p), {5'd0, getTc(p)}, 8'd0);
         checkOutput($sformatf("t6_rst_te%0d", p), {7'd0, getTe(p)}, 8'd0);
      end
      rstn   = 1'b1;
      bus.we = 1'b0;
      tick();
      tick();
      checkOutput("t6_tcA", {5'd0, bus.t_c_A}, 8'h05);
      checkOutput("t6_teA", {7'd0, bus.transpose_en_outA}, 8'h00);
      checkOutput("t6_tcB", {5'd0, bus.t_c_B}, {5'd0, expNeg});
      checkOutput("t6_teB", {7'd0, bus.transpose_en_outB}, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
